ram_dp_sync: RTL

- Parametrised, fully synchronous dual-port word-addressed memory for the pipelined core.
- Port A: read-only instruction fetch. Port B: load/store data access with byte enables.
- Separate read and write data buses; no tri-state bus.
- Built-in clear sequencer zeroes the array after reset; handshaked valid outputs with one-cycle read latency.

---
 rtl/ram_dp_sync_if.sv | 54 +++++
 rtl/ram_dp_sync.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_sync_if.sv
// ram_dp_sync_if: request/response bundle for the dual-port synchronous RAM.
//   Port A : a_en, a_addr -> a_rdata, a_valid            (read-only fetch)
//   Port B : b_en, b_we, b_be, b_addr, b_wdata -> b_rdata, b_valid, b_err
//   Status : busy (clear sequencer running)
//   Optional (RAM_PARITY_EN): inj_perr -> a_perr, b_perr
// master = requester side, slave = memory side.
interface ram_dp_sync_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              a_en;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_rdata;
  logic              a_valid;

  logic              b_en;
  logic              b_we;
  logic [BE_W-1:0]   b_be;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] b_rdata;
  logic              b_valid;
  logic              b_err;

  logic              busy;

`ifdef RAM_PARITY_EN
  logic              inj_perr;
  logic              a_perr;
  logic              b_perr;

  modport master (
    output a_en, a_addr, b_en, b_we, b_be, b_addr, b_wdata, inj_perr,
    input  a_rdata, a_valid, b_rdata, b_valid, b_err, busy, a_perr, b_perr
  );

  modport slave (
    input  a_en, a_addr, b_en, b_we, b_be, b_addr, b_wdata, inj_perr,
    output a_rdata, a_valid, b_rdata, b_valid, b_err, busy, a_perr, b_perr
  );
`else
  modport master (
    output a_en, a_addr, b_en, b_we, b_be, b_addr, b_wdata,
    input  a_rdata, a_valid, b_rdata, b_valid, b_err, busy
  );

  modport slave (
    input  a_en, a_addr, b_en, b_we, b_be, b_addr, b_wdata,
    output a_rdata, a_valid, b_rdata, b_valid, b_err, busy
  );
`endif
endinterface

// File: rtl/ram_dp_sync.sv
// ram_dp_sync: fully synchronous dual-port word-addressed RAM.
//   Port A read-only, port B read/write with byte enables, one-cycle read
//   latency with registered valid strobes. A clear sequencer zeroes the array
//   after reset (CLEAR_ON_RESET=1); requests are ignored while busy.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : ram_dp_sync_if.slave (see interface header for signal list)
// Optional feature macro: RAM_PARITY_EN (per-lane even parity, a_perr/b_perr,
//   inj_perr error injection on port B writes).
module ram_dp_sync #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 128,
  parameter int unsigned ADDR_W         = $clog2(DEPTH),
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic          clk,
  input logic          reset,
  ram_dp_sync_if.slave bus
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic              a_valid_q, a_valid_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              b_valid_q, b_valid_d;
  logic              b_err_q, b_err_d;

  // Single write port into the array, shared by clear sequencer and port B
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  logic [DATA_W-1:0] mem [DEPTH];

  logic a_in_rng, b_in_rng;

  // Addresses at or above DEPTH only exist when DEPTH is not a power of two
  assign a_in_rng = ({1'b0, bus.a_addr} < DEPTH_L);
  assign b_in_rng = ({1'b0, bus.b_addr} < DEPTH_L);

`ifdef RAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [BE_W-1:0] wr_par;
  logic            a_perr_q, a_perr_d;
  logic            b_perr_q, b_perr_d;

  // Even parity per byte lane
  function automatic logic [BE_W-1:0] lane_par(input logic [DATA_W-1:0] d);
    logic [BE_W-1:0] p;
    for (int i = 0; i < int'(BE_W); i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction
`endif

  // Next-state, array write control and registered output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    a_valid_d = 1'b0;
    b_rdata_d = b_rdata_q;
    b_valid_d = 1'b0;
    b_err_d   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = cnt_q;
    wr_data   = '0;
    wr_be     = '0;
`ifdef RAM_PARITY_EN
    wr_par    = '0;
    a_perr_d  = 1'b0;
    b_perr_d  = 1'b0;
`endif

    case (state_q)
      ST_CLEAR: begin
        wr_en = 1'b1;
        wr_be = '1;
        cnt_d = ADDR_W'(cnt_q + 1'b1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_READY;
        end
      end

      ST_READY: begin
        if (bus.a_en) begin
          // Array read happens before this edge's write lands: read-first
          a_valid_d = 1'b1;
          a_rdata_d = a_in_rng ? mem[bus.a_addr] : '0;
`ifdef RAM_PARITY_EN
          a_perr_d  = a_in_rng &&
                      (|(lane_par(mem[bus.a_addr]) ^ par_mem[bus.a_addr]));
`endif
        end

        if (bus.b_en) begin
          if (!b_in_rng) begin
            b_err_d = 1'b1;
          end else if (bus.b_we) begin
            wr_en   = 1'b1;
            wr_addr = bus.b_addr;
            wr_data = bus.b_wdata;
            wr_be   = bus.b_be;
`ifdef RAM_PARITY_EN
            wr_par  = lane_par(bus.b_wdata) ^ {BE_W{bus.inj_perr}};
`endif
          end else begin
            b_valid_d = 1'b1;
            b_rdata_d = mem[bus.b_addr];
`ifdef RAM_PARITY_EN
            b_perr_d  = |(lane_par(mem[bus.b_addr]) ^ par_mem[bus.b_addr]);
`endif
          end
        end
      end

      default: state_d = ST_READY;
    endcase

    // The array is frozen while reset is asserted
    if (!reset) begin
      wr_en = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt_q     <= '0;
      a_rdata_q <= '0;
      a_valid_q <= 1'b0;
      b_rdata_q <= '0;
      b_valid_q <= 1'b0;
      b_err_q   <= 1'b0;
`ifdef RAM_PARITY_EN
      a_perr_q  <= 1'b0;
      b_perr_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      a_valid_q <= a_valid_d;
      b_rdata_q <= b_rdata_d;
      b_valid_q <= b_valid_d;
      b_err_q   <= b_err_d;
`ifdef RAM_PARITY_EN
      a_perr_q  <= a_perr_d;
      b_perr_q  <= b_perr_d;
`endif
    end
  end

  // Byte-lane masked array write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

`ifdef RAM_PARITY_EN
  // Parity bits follow their data lanes
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (wr_be[i]) begin
          par_mem[wr_addr][i] <= wr_par[i];
        end
      end
    end
  end

  assign bus.a_perr = a_perr_q;
  assign bus.b_perr = b_perr_q;
`endif

  assign bus.a_rdata = a_rdata_q;
  assign bus.a_valid = a_valid_q;
  assign bus.b_rdata = b_rdata_q;
  assign bus.b_valid = b_valid_q;
  assign bus.b_err   = b_err_q;
  assign bus.busy    = (state_q == ST_CLEAR);

endmodule
